// File: rtl/ws2801_driver.sv
// WS2801 frame serializer: fetches NUM_LEDS RGB words from a synchronous
// colour buffer, shifts each out MSB-first on sdo/cko, then holds cko low
// long enough for the whole chain to latch.
module ws2801_driver #(
  parameter int NUM_LEDS     = 12,
  parameter int CLK_DIV      = 25,
  parameter int LATCH_CYCLES = 30000,
  parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [23:0]   rd_data,
  output logic          sdo,
  output logic          cko
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_LEDS - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_LATCH
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [4:0]      bit_cnt, bit_n;
  logic [LW-1:0]   latch_cnt, latch_n;
  logic [AW-1:0]   idx_n;
  logic [23:0]     shreg, shreg_n;
  logic            busy_n, done_n, rd_en_n, cko_n;

  // sdo is the shift register MSB; the register is cleared whenever the
  // serial data must idle low, and 24 shifts per LED leave it empty.
  assign sdo = shreg[23];

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      latch_cnt <= '0;
      rd_addr   <= '0;
      shreg     <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      cko       <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      latch_cnt <= latch_n;
      rd_addr   <= idx_n;
      shreg     <= shreg_n;
      busy      <= busy_n;
      done      <= done_n;
      rd_en     <= rd_en_n;
      cko       <= cko_n;
    end
  end

  // Next-state and next-output values; outputs are the registered copies.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    latch_n = latch_cnt;
    idx_n   = rd_addr;
    shreg_n = shreg;
    busy_n  = busy;
    done_n  = 1'b0;
    rd_en_n = 1'b0;
    cko_n   = cko;
    case (state)
      S_INIT, S_LATCH: begin
        cko_n   = 1'b0;
        shreg_n = '0;
        if (latch_cnt == LATCH_LAST) begin
          state_n = S_IDLE;
          latch_n = '0;
          busy_n  = 1'b0;
          done_n  = (state == S_LATCH);
        end else begin
          latch_n = latch_cnt + LW'(1);
        end
      end
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = S_FETCH;
          idx_n   = '0;
          rd_en_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      S_FETCH: begin
        state_n = S_LOAD;
      end
      S_LOAD: begin
        shreg_n = rd_data;
        bit_n   = 5'd23;
        div_n   = '0;
        cko_n   = 1'b0;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (!cko) begin
            cko_n = 1'b1;
          end else begin
            // End of a bit's high phase: the next bit appears while cko is low.
            cko_n   = 1'b0;
            shreg_n = {shreg[22:0], 1'b0};
            if (bit_cnt == 5'd0) begin
              if (rd_addr == LAST_IDX) begin
                state_n = S_LATCH;
                latch_n = '0;
              end else begin
                idx_n   = rd_addr + AW'(1);
                rd_en_n = 1'b1;
                state_n = S_FETCH;
              end
            end else begin
              bit_n = bit_cnt - 5'd1;
            end
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      default: state_n = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_ws2801_driver.sv
// Bench for ws2801_driver: a cycle-timeline model checks every output of a
// 2-LED instance each cycle; a two-LED WS2801 chain model and hand-computed
// literals cover bit order, latching, back-to-back frames and reset recovery.
// A second instance covers the NUM_LEDS=1, CLK_DIV=1 corner.
module tb_ws2801_driver;

  localparam int NA = 2, DA = 2, LA = 10;
  localparam int PA = 2 + 48 * DA;
  localparam int FA = NA * PA + LA;
  localparam int NB = 1, DB = 1, LB = 10;
  localparam int LTH = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, busy_a, done_a, rd_en_a, sdo_a, cko_a;
  logic [0:0]  rd_addr_a;
  logic [23:0] rd_data_a;
  logic        rst_b, start_b, busy_b, done_b, rd_en_b, sdo_b, cko_b;
  logic [0:0]  rd_addr_b;
  logic [23:0] rd_data_b;

  logic [23:0] mem_a [NA];
  logic [23:0] mem_b;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  ws2801_driver #(.NUM_LEDS(NA), .CLK_DIV(DA), .LATCH_CYCLES(LA)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .sdo(sdo_a), .cko(cko_a)
  );

  ws2801_driver #(.NUM_LEDS(NB), .CLK_DIV(DB), .LATCH_CYCLES(LB)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .sdo(sdo_b), .cko(cko_b)
  );

  // Synchronous colour buffers and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b;
  end

  // Observers: WS2801 chain model (first 24 bits stay in LED0, later bits
  // pass to LED1, a long cko-low run latches), edge and strobe counters.
  logic        cko_a_prev = 1'b0, cko_b_prev = 1'b0;
  int          rises_a = 0, rden_a = 0, dones_a = 0, led_bits = 0, low_cnt = 0;
  int          rises_b = 0, highs_b = 0, rden_b = 0;
  logic [47:0] cap_a = '0;
  logic [23:0] cap_b = '0;
  logic [23:0] sh0 = '0, sh1 = '0, disp0 = '0, disp1 = '0;
  logic [1:0]  addr_hist = '0;
  logic        addr_bad_b = 1'b0;

  always @(posedge clk) begin
    cko_a_prev <= cko_a;
    if (cko_a && !cko_a_prev) begin
      rises_a <= rises_a + 1;
      cap_a   <= {cap_a[46:0], sdo_a};
      if (led_bits < 24) sh0 <= {sh0[22:0], sdo_a};
      else               sh1 <= {sh1[22:0], sdo_a};
      led_bits <= led_bits + 1;
    end
    if (cko_a) begin
      low_cnt <= 0;
    end else begin
      low_cnt <= low_cnt + 1;
      if (low_cnt == LTH) begin
        disp0    <= sh0;
        disp1    <= sh1;
        led_bits <= 0;
      end
    end
    if (rd_en_a) begin
      rden_a    <= rden_a + 1;
      addr_hist <= {addr_hist[0], rd_addr_a};
    end
    if (done_a) dones_a <= dones_a + 1;
    cko_b_prev <= cko_b;
    if (cko_b && !cko_b_prev) begin
      rises_b <= rises_b + 1;
      cap_b   <= {cap_b[22:0], sdo_b};
    end
    if (cko_b) highs_b <= highs_b + 1;
    if (rd_en_b) rden_b <= rden_b + 1;
    if (rd_addr_b != 1'b0) addr_bad_b <= 1'b1;
  end

  // Timeline model for instance A: mode plus cycles elapsed in that mode.
  typedef enum {M_INIT, M_IDLE, M_FRAME} mode_t;
  mode_t       m_mode;
  int          m_cnt;
  logic        m_from_frame;
  logic        m_addr;
  logic [23:0] m_word [NA];

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      m_mode       <= M_INIT;
      m_cnt        <= 0;
      m_from_frame <= 1'b0;
      m_addr       <= 1'b0;
    end else begin
      case (m_mode)
        M_INIT: begin
          if (m_cnt == LA - 1) begin m_mode <= M_IDLE; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
        M_IDLE: begin
          m_from_frame <= 1'b0;
          if (start_a) begin
            m_mode <= M_FRAME;
            m_cnt  <= 0;
            for (int i = 0; i < NA; i++) m_word[i] <= mem_a[i];
          end
        end
        default: begin
          if (m_cnt == FA - 1) begin
            m_mode       <= M_IDLE;
            m_cnt        <= 0;
            m_from_frame <= 1'b1;
            m_addr       <= 1'(NA - 1);
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      endcase
    end
  end

  // Expected {busy, done, rd_en, rd_addr, sdo, cko} for the current cycle.
  function automatic logic [5:0] expect_a();
    logic bz, dn, re, ad, sd, ck;
    int k, led, r, s, b;
    logic [23:0] w;
    bz = 1'b1; dn = 1'b0; re = 1'b0; ad = m_addr; sd = 1'b0; ck = 1'b0;
    if (m_mode == M_IDLE) begin
      bz = 1'b0;
      dn = m_from_frame;
    end else if (m_mode == M_FRAME) begin
      k = m_cnt;
      if (k < NA * PA) begin
        led = k / PA;
        r   = k % PA;
        ad  = led[0];
        re  = (r == 0);
        if (r >= 2) begin
          s  = r - 2;
          b  = s / (2 * DA);
          ck = (s % (2 * DA)) >= DA;
          w  = m_word[led];
          sd = w[23 - b];
        end
      end else begin
        ad = 1'(NA - 1);
      end
    end
    return {bz, dn, re, ad, sd, ck};
  endfunction

  // Per-cycle comparison of instance A against the timeline model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({busy_a, done_a, rd_en_a, rd_addr_a, sdo_a, cko_a} !== expect_a()) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t: got busy,done,rd_en,addr,sdo,cko=%b required %b",
                 $time, {busy_a, done_a, rd_en_a, rd_addr_a, sdo_a, cko_a}, expect_a());
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int sel, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? done_a : done_b) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, required one", limit);
    end
  endtask

  task automatic count_busy_a(input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      n++;
      if (!busy_a) break;
    end
  endtask

  task automatic run_frame_a(input logic [23:0] w0, input logic [23:0] w1);
    int d;
    mem_a[0] = w0;
    mem_a[1] = w1;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_done(0, 1000, d);
    step(2);
  endtask

  initial begin
    int t, d, d1, d2, n, b_r, b_d, b_e, b_h;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mem_a[0] = 24'hA5C3F0; mem_a[1] = 24'h0F1E2D; mem_b = 24'h3C96E1;
    step(3);
    chk_en = 1'b1;
    check("reset_outputs", 64'({busy_a, done_a, rd_en_a, rd_addr_a, sdo_a, cko_a}), 64'b100000);
    rst_a = 1'b0; rst_b = 1'b0;
    count_busy_a(100, n);
    check("init_length", 64'(n), 64'(LA));
    step(1);

    // Cycle accounting and bit order.
    t = cyc; b_r = rises_a;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    check("busy_rise", 64'(busy_a), 64'(1));
    wait_done(0, 1000, d);
    check("done_cycle", 64'(d - t), 64'(207));
    check("busy_at_done", 64'(busy_a), 64'(0));
    step(2);
    check("cko_rises", 64'(rises_a - b_r), 64'(48));
    check("bits_led0", 64'(cap_a[47:24]), 64'h0A5C3F0);
    check("bits_led1", 64'(cap_a[23:0]), 64'h00F1E2D);
    check("addr_order", 64'(addr_hist), 64'b01);

    // Chain latching, two frames.
    run_frame_a(24'hFF0000, 24'h00FF00);
    check("led0_frame1", 64'(disp0), 64'hFF0000);
    check("led1_frame1", 64'(disp1), 64'h00FF00);
    run_frame_a(24'h123456, 24'h654321);
    check("led0_frame2", 64'(disp0), 64'h123456);
    check("led1_frame2", 64'(disp1), 64'h654321);

    // Back-to-back frames with start held; pulses during busy are ignored.
    b_d = dones_a; b_e = rden_a;
    start_a = 1'b1;
    wait_done(0, 1000, d1);
    step(1);
    for (int i = 0; i < 10; i++) begin
      start_a = (i % 2 == 0);
      step(1);
    end
    start_a = 1'b0;
    wait_done(0, 1000, d2);
    step(2);
    check("b2b_gap", 64'(d2 - d1), 64'(207));
    check("b2b_dones", 64'(dones_a - b_d), 64'(2));
    check("b2b_rd_en", 64'(rden_a - b_e), 64'(4));

    // Reset after 30 bits, then recovery.
    mem_a[0] = 24'hABCDEF; mem_a[1] = 24'h135790;
    b_r = rises_a; b_d = dones_a;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (rises_a - b_r >= 30) break;
      step(1);
    end
    check("rises_before_reset", 64'(rises_a - b_r), 64'(30));
    check("cko_before_reset", 64'(cko_a), 64'(1));
    #1 rst_a = 1'b1;
    #1 check("reset_async_drop", 64'({busy_a, sdo_a, cko_a}), 64'b100);
    step(2);
    rst_a = 1'b0;
    count_busy_a(100, n);
    check("reinit_length", 64'(n), 64'(LA));
    step(1);
    check("no_done_after_reset", 64'(dones_a - b_d), 64'(0));
    run_frame_a(24'h0A0B0C, 24'hD0E0F0);
    check("led0_after_reset", 64'(disp0), 64'h0A0B0C);
    check("led1_after_reset", 64'(disp1), 64'hD0E0F0);

    // Single LED, CLK_DIV=1 corner on instance B.
    check("b_idle", 64'(busy_b), 64'(0));
    t = cyc; b_r = rises_b; b_h = highs_b; b_e = rden_b;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    wait_done(1, 200, d);
    check("b_done_cycle", 64'(d - t), 64'(1 + 50 + LB));
    step(2);
    check("b_cko_rises", 64'(rises_b - b_r), 64'(24));
    check("b_cko_high_cycles", 64'(highs_b - b_h), 64'(24));
    check("b_bits", 64'(cap_b), 64'h3C96E1);
    check("b_rd_en", 64'(rden_b - b_e), 64'(1));
    check("b_addr_zero", 64'(addr_bad_b), 64'(0));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

endmodule
